// File: rtl/pll_cfg_seq.sv
// Upstream sequencer for the CGU PLL wrapper: validates a divider request, drives the
// configuration bus with a single setcfg strobe, then qualifies the synchronised PLL lock.
module pll_cfg_seq #(
    parameter int unsigned PREDIV_W    = 5,
    parameter int unsigned FBDIV_W     = 12,
    parameter int unsigned FRAC_W      = 24,
    parameter int unsigned POSTDIV_W   = 3,
    parameter int unsigned NI_MIN      = 16,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned LOCK_STABLE = 32,
    parameter int unsigned TIMEOUT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_req,
    input  logic                 cfg_off,
    input  logic [PREDIV_W-1:0]  cfg_m,
    input  logic [FBDIV_W-1:0]   cfg_n,
    input  logic [FRAC_W-1:0]    cfg_f,
    input  logic                 cfg_fen,
    input  logic [POSTDIV_W-1:0] cfg_q00,
    input  logic [POSTDIV_W-1:0] cfg_q10,
    input  logic [POSTDIV_W-1:0] cfg_q01,
    input  logic [POSTDIV_W-1:0] cfg_q11,
    input  logic [TIMEOUT_W-1:0] timeout_lim,
    input  logic                 pll_lock,
    output logic                 pllen,
    output logic                 setcfg,
    output logic [PREDIV_W-1:0]  pll_m,
    output logic [FBDIV_W-1:0]   pll_n,
    output logic [FRAC_W-1:0]    pll_f,
    output logic                 pll_fen,
    output logic [POSTDIV_W-1:0] pll_q00,
    output logic [POSTDIV_W-1:0] pll_q10,
    output logic [POSTDIV_W-1:0] pll_q01,
    output logic [POSTDIV_W-1:0] pll_q11,
    output logic                 busy,
    output logic                 locked,
    output logic                 done,
    output logic                 err_inval,
    output logic                 err_timeout,
    output logic                 lost_lock
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SETTLE, S_WAIT_LOCK, S_LOCKED, S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic                 lock_meta_q, lock_s_q;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [STB_W-1:0]     stable_q, stable_d, stable_inc;
    logic [TIMEOUT_W-1:0] to_q, to_d, to_inc;
    logic                 pllen_q, pllen_d;
    logic                 done_q, done_d;
    logic                 err_inval_q, err_inval_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 lost_lock_q, lost_lock_d;
    logic [PREDIV_W-1:0]  m_q, m_d;
    logic [FBDIV_W-1:0]   n_q, n_d;
    logic [FRAC_W-1:0]    f_q, f_d;
    logic                 fen_q, fen_d;
    logic [POSTDIV_W-1:0] q00_q, q00_d, q10_q, q10_d, q01_q, q01_d, q11_q, q11_d;
    logic                 req_window, req_valid;

    assign req_window = (state_q == S_IDLE) || (state_q == S_LOCKED) || (state_q == S_ERR);
    assign req_valid  = (cfg_m != '0) && (cfg_n >= FBDIV_W'(NI_MIN));
    // Counters saturate at their terminal value instead of wrapping.
    assign stable_inc = (stable_q == STB_W'(LOCK_STABLE)) ? stable_q : stable_q + 1'b1;
    assign to_inc     = (to_q == '1) ? to_q : to_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        stable_d      = stable_q;
        to_d          = to_q;
        pllen_d       = pllen_q;
        done_d        = 1'b0;
        err_inval_d   = err_inval_q;
        err_timeout_d = err_timeout_q;
        lost_lock_d   = lost_lock_q;
        m_d   = m_q;   n_d   = n_q;   f_d   = f_q;   fen_d = fen_q;
        q00_d = q00_q; q10_d = q10_q; q01_d = q01_q; q11_d = q11_q;

        if (cfg_off) begin
            state_d       = S_IDLE;
            pllen_d       = 1'b0;
            settle_d      = '0;
            stable_d      = '0;
            to_d          = '0;
            err_inval_d   = 1'b0;
            err_timeout_d = 1'b0;
            lost_lock_d   = 1'b0;
        end else if (cfg_req && req_window && req_valid) begin
            state_d       = S_APPLY;
            pllen_d       = 1'b1;
            settle_d      = '0;
            stable_d      = '0;
            to_d          = '0;
            err_inval_d   = 1'b0;
            err_timeout_d = 1'b0;
            lost_lock_d   = 1'b0;
            m_d   = cfg_m;   n_d   = cfg_n;   f_d   = cfg_f;   fen_d = cfg_fen;
            q00_d = cfg_q00; q10_d = cfg_q10; q01_d = cfg_q01; q11_d = cfg_q11;
        end else begin
            // A rejected request only flags the error; lock supervision still runs.
            if (cfg_req && req_window) begin
                err_inval_d = 1'b1;
            end
            case (state_q)
                S_IDLE, S_ERR: ;
                S_APPLY: begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end
                S_SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                        state_d  = S_WAIT_LOCK;
                        stable_d = '0;
                        to_d     = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    stable_d = lock_s_q ? stable_inc : '0;
                    to_d     = to_inc;
                    if (lock_s_q && (stable_inc == STB_W'(LOCK_STABLE))) begin
                        state_d = S_LOCKED;
                        done_d  = 1'b1;
                    end else if ((timeout_lim != '0) && (to_inc >= timeout_lim)) begin
                        state_d       = S_ERR;
                        err_timeout_d = 1'b1;
                        done_d        = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (!lock_s_q) begin
                        state_d     = S_WAIT_LOCK;
                        lost_lock_d = 1'b1;
                        stable_d    = '0;
                        to_d        = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            lock_meta_q   <= 1'b0;
            lock_s_q      <= 1'b0;
            settle_q      <= '0;
            stable_q      <= '0;
            to_q          <= '0;
            pllen_q       <= 1'b0;
            done_q        <= 1'b0;
            err_inval_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            lost_lock_q   <= 1'b0;
            m_q   <= '0; n_q   <= '0; f_q   <= '0; fen_q <= 1'b0;
            q00_q <= '0; q10_q <= '0; q01_q <= '0; q11_q <= '0;
        end else begin
            state_q       <= state_d;
            lock_meta_q   <= pll_lock;
            lock_s_q      <= lock_meta_q;
            settle_q      <= settle_d;
            stable_q      <= stable_d;
            to_q          <= to_d;
            pllen_q       <= pllen_d;
            done_q        <= done_d;
            err_inval_q   <= err_inval_d;
            err_timeout_q <= err_timeout_d;
            lost_lock_q   <= lost_lock_d;
            m_q   <= m_d;   n_q   <= n_d;   f_q   <= f_d;   fen_q <= fen_d;
            q00_q <= q00_d; q10_q <= q10_d; q01_q <= q01_d; q11_q <= q11_d;
        end
    end

    // APPLY lasts exactly one cycle, so it doubles as the setcfg strobe.
    assign setcfg      = (state_q == S_APPLY);
    assign busy        = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_WAIT_LOCK);
    assign locked      = (state_q == S_LOCKED);
    assign pllen       = pllen_q;
    assign done        = done_q;
    assign err_inval   = err_inval_q;
    assign err_timeout = err_timeout_q;
    assign lost_lock   = lost_lock_q;
    assign pll_m       = m_q;
    assign pll_n       = n_q;
    assign pll_f       = f_q;
    assign pll_fen     = fen_q;
    assign pll_q00     = q00_q;
    assign pll_q10     = q10_q;
    assign pll_q01     = q01_q;
    assign pll_q11     = q11_q;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Directed bench for pll_cfg_seq: request/lock sequencing, rejection, lost lock,
// timeout, cfg_off priority and mid-sequence reset.
module tb_pll_cfg_seq;

    logic        clk = 1'b0;
    logic        reset, cfg_req, cfg_off, cfg_fen, pll_lock;
    logic [4:0]  cfg_m;
    logic [11:0] cfg_n;
    logic [23:0] cfg_f;
    logic [2:0]  cfg_q00, cfg_q10, cfg_q01, cfg_q11;
    logic [15:0] timeout_lim;
    logic        pllen, setcfg, pll_fen, busy, locked, done;
    logic        err_inval, err_timeout, lost_lock;
    logic [4:0]  pll_m;
    logic [11:0] pll_n;
    logic [23:0] pll_f;
    logic [2:0]  pll_q00, pll_q10, pll_q01, pll_q11;

    int n_cmp = 0;
    int n_mis = 0;
    int n, dones, tog, sc, lk;

    pll_cfg_seq #(
        .PREDIV_W(5), .FBDIV_W(12), .FRAC_W(24), .POSTDIV_W(3),
        .NI_MIN(16), .SETTLE_CYC(16), .LOCK_STABLE(32), .TIMEOUT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .cfg_req(cfg_req), .cfg_off(cfg_off),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_f(cfg_f), .cfg_fen(cfg_fen),
        .cfg_q00(cfg_q00), .cfg_q10(cfg_q10), .cfg_q01(cfg_q01), .cfg_q11(cfg_q11),
        .timeout_lim(timeout_lim), .pll_lock(pll_lock),
        .pllen(pllen), .setcfg(setcfg),
        .pll_m(pll_m), .pll_n(pll_n), .pll_f(pll_f), .pll_fen(pll_fen),
        .pll_q00(pll_q00), .pll_q10(pll_q10), .pll_q01(pll_q01), .pll_q11(pll_q11),
        .busy(busy), .locked(locked), .done(done),
        .err_inval(err_inval), .err_timeout(err_timeout), .lost_lock(lost_lock)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [4:0] m, input logic [11:0] nn, input logic [23:0] f,
                           input logic fen, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [2:0] d);
        cfg_m = m; cfg_n = nn; cfg_f = f; cfg_fen = fen;
        cfg_q00 = a; cfg_q10 = b; cfg_q01 = c; cfg_q11 = d;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cfg_req = 1'b0; cfg_off = 1'b0; pll_lock = 1'b0; timeout_lim = '0;
        set_cfg(5'd0, 12'd0, 24'd0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        step(); step();
        check("rst_pllen", pllen, 0);
        check("rst_setcfg", setcfg, 0);
        check("rst_busy", busy, 0);
        check("rst_locked", locked, 0);
        check("rst_done", done, 0);
        check("rst_errs", {err_inval, err_timeout, lost_lock}, 0);
        check("rst_pll_m", pll_m, 0);
        check("rst_pll_n", pll_n, 0);

        reset = 1'b0; pll_lock = 1'b1;
        step(); step(); step();

        // Lock input already synced high, so lock is declared 1+1+16+32 edges after the request edge.
        set_cfg(5'd31, 12'd1432, 24'h123456, 1'b1, 3'd1, 3'd0, 3'd7, 3'd1);
        cfg_req = 1'b1;
        step(); cfg_req = 1'b0;
        check("t1_setcfg_hi", setcfg, 1);
        check("t1_pllen", pllen, 1);
        check("t1_busy", busy, 1);
        check("t1_pll_m", pll_m, 31);
        check("t1_pll_n", pll_n, 1432);
        check("t1_pll_f", pll_f, 24'h123456);
        check("t1_pll_q", {pll_fen, pll_q00, pll_q10, pll_q01, pll_q11}, {1'b1, 3'd1, 3'd0, 3'd7, 3'd1});
        step();
        check("t1_setcfg_lo", setcfg, 0);
        n = 2; dones = 0;
        while (!locked && n < 200) begin
            step(); n++; dones += int'(done);
        end
        check("t1_lock_latency", n, 50);
        check("t1_busy_lo", busy, 0);
        for (int i = 0; i < 5; i++) begin
            step(); dones += int'(done);
        end
        check("t1_done_count", dones, 1);

        // Rejected requests while LOCKED: M=0, then N below NI_MIN.
        set_cfg(5'd0, 12'd1000, 24'd0, 1'b0, 3'd2, 3'd2, 3'd2, 3'd2);
        cfg_req = 1'b1;
        step(); cfg_req = 1'b0;
        check("inv_m_err", err_inval, 1);
        check("inv_m_setcfg", setcfg, 0);
        check("inv_m_pllen", pllen, 1);
        check("inv_m_pll_m", pll_m, 31);
        check("inv_m_locked", locked, 1);
        set_cfg(5'd5, 12'd8, 24'd0, 1'b0, 3'd2, 3'd2, 3'd2, 3'd2);
        cfg_req = 1'b1;
        step(); cfg_req = 1'b0;
        check("inv_n_setcfg", setcfg, 0);
        check("inv_n_pll_n", pll_n, 1432);
        check("inv_n_pll_q00", pll_q00, 1);
        step();
        check("inv_sticky", err_inval, 1);

        // Lost lock: 5-cycle dropout, seen after the 2-flop sync plus one FSM edge.
        pll_lock = 1'b0;
        step(); step();
        check("ll_locked_still", locked, 1);
        step();
        check("ll_locked_lo", locked, 0);
        check("ll_lost_lock", lost_lock, 1);
        check("ll_busy", busy, 1);
        check("ll_done", done, 0);
        step(); step();
        pll_lock = 1'b1;
        n = 5; dones = 0;
        while (!locked && n < 200) begin
            step(); n++; dones += int'(done);
        end
        check("ll_relock_latency", n, 39);
        check("ll_relock_done", dones, 1);
        check("ll_lost_sticky", lost_lock, 1);

        // New request from LOCKED; a second request during WAIT_LOCK must be ignored.
        set_cfg(5'd25, 12'd1482, 24'd0, 1'b0, 3'd2, 3'd3, 3'd4, 3'd5);
        cfg_req = 1'b1;
        step(); cfg_req = 1'b0;
        check("t2_setcfg", setcfg, 1);
        check("t2_pll_m", pll_m, 25);
        check("t2_pll_n", pll_n, 1482);
        check("t2_flags_clr", {err_inval, lost_lock, locked}, 0);
        for (int i = 0; i < 20; i++) step();
        set_cfg(5'd9, 12'd500, 24'd7, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0);
        cfg_req = 1'b1;
        step(); cfg_req = 1'b0;
        check("t2_ign_setcfg", setcfg, 0);
        check("t2_ign_pll_m", pll_m, 25);
        check("t2_ign_err", err_inval, 0);
        n = 22;
        while (!locked && n < 200) begin
            step(); n++;
        end
        check("t2_lock_latency", n, 50);
        check("t2_pll_q", {pll_q00, pll_q10, pll_q01, pll_q11}, {3'd2, 3'd3, 3'd4, 3'd5});

        // Timeout: lock toggles every 20 cycles, never 32 stable; ERR after 500 WAIT_LOCK cycles.
        timeout_lim = 16'd500; pll_lock = 1'b0;
        set_cfg(5'd3, 12'd100, 24'd0, 1'b0, 3'd1, 3'd1, 3'd1, 3'd1);
        cfg_req = 1'b1;
        step(); cfg_req = 1'b0;
        n = 1; tog = 0; dones = 0;
        while (!err_timeout && n < 700) begin
            step(); n++; tog++;
            dones += int'(done);
            if (tog == 20) begin
                pll_lock = ~pll_lock; tog = 0;
            end
        end
        check("to_latency", n, 518);
        check("to_done", dones, 1);
        check("to_pllen", pllen, 1);
        check("to_busy", busy, 0);
        check("to_locked", locked, 0);

        // Boundary-legal request (M=1, N=NI_MIN), then req+off together during SETTLE.
        timeout_lim = '0; pll_lock = 1'b1;
        set_cfg(5'd1, 12'd16, 24'd0, 1'b0, 3'd6, 3'd6, 3'd6, 3'd6);
        cfg_req = 1'b1;
        step(); cfg_req = 1'b0;
        check("off_setcfg_min", setcfg, 1);
        check("off_err_clr", err_timeout, 0);
        step(); step(); step(); step();
        check("off_busy_settle", busy, 1);
        set_cfg(5'd7, 12'd700, 24'd0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        cfg_req = 1'b1; cfg_off = 1'b1;
        step(); cfg_req = 1'b0; cfg_off = 1'b0;
        check("off_pllen", pllen, 0);
        check("off_busy", busy, 0);
        check("off_setcfg", setcfg, 0);
        check("off_pll_m", pll_m, 1);
        check("off_pll_n", pll_n, 16);
        sc = 0; lk = 0;
        for (int i = 0; i < 40; i++) begin
            step(); sc += int'(setcfg); lk += int'(locked);
        end
        check("off_no_setcfg", sc, 0);
        check("off_no_lock", lk, 0);

        // N = NI_MIN-1 is rejected in IDLE.
        set_cfg(5'd1, 12'd15, 24'd0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        cfg_req = 1'b1;
        step(); cfg_req = 1'b0;
        check("inv_n15_err", err_inval, 1);
        check("inv_n15_setcfg", setcfg, 0);
        check("inv_n15_pllen", pllen, 0);

        // Reset while setcfg is high.
        set_cfg(5'd2, 12'd200, 24'd0, 1'b0, 3'd1, 3'd1, 3'd1, 3'd1);
        cfg_req = 1'b1;
        step(); cfg_req = 1'b0;
        check("rs_setcfg_hi", setcfg, 1);
        reset = 1'b1;
        step();
        check("rs_setcfg_lo", setcfg, 0);
        check("rs_pllen", pllen, 0);
        check("rs_busy", busy, 0);
        check("rs_pll_m", pll_m, 0);
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
